// File: rtl/capture_ctrl_if.sv
// Signal bundle between capture_ctrl and its neighbours: MAC receive side,
// comparator bank, input FIFO and capture memory.
interface capture_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
);
  // Handshakes: sop/eop are qualified by data_valid, and a MAC word enters
  // the FIFO only on a cycle with wrreq=1 (a word with fifo_full=1 is lost).
  // rdreq pops one FIFO word per cycle while rdempty=0, and its data appears
  // on the cycle after rdreq; mem_wr marks that cycle for the capture memory.
  logic              cfg_done;
  logic              data_valid;
  logic              sop;
  logic              eop;
  logic              error;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] enable_mask;
  logic              fifo_full;
  logic              rdempty;
  logic              wrreq;
  logic              rdreq;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic              clear;
  logic [NUM_CH-1:0] capture_ch;
  logic [CNT_W-1:0]  pkt_count;
  logic [CNT_W-1:0]  drop_count;
  logic              busy;
  logic [2:0]        state_dbg;

  modport master (
    output cfg_done, data_valid, sop, eop, error, match, enable_mask,
           fifo_full, rdempty,
    input  wrreq, rdreq, mem_wr, mem_addr, clear, capture_ch, pkt_count,
           drop_count, busy, state_dbg
  );

  modport slave (
    input  cfg_done, data_valid, sop, eop, error, match, enable_mask,
           fifo_full, rdempty,
    output wrreq, rdreq, mem_wr, mem_addr, clear, capture_ch, pkt_count,
           drop_count, busy, state_dbg
  );
endinterface

// File: rtl/capture_ctrl.sv
// Packet-capture controller: buffers MAC words in the input FIFO, decides at
// end of packet whether an enabled comparator matched, then stores or flushes.
module capture_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 380,
  parameter int CNT_W     = 16
) (
  input logic           clk,
  input logic           n_rst,
  capture_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_CFG      = 3'd0,
    S_IDLE     = 3'd1,
    S_RECEIVE  = 3'd2,
    S_DECIDE   = 3'd3,
    S_STORE    = 3'd4,
    S_DISCARD  = 3'd5,
    S_ERR_WAIT = 3'd6
  } state_t;

  localparam int WC_W = $clog2(MAX_WORDS + 1);
  // word_cnt holds the words already taken, so the incoming word is the
  // last legal one when word_cnt equals MAX_WORDS-1.
  localparam logic [WC_W-1:0] LAST_CNT = WC_W'(MAX_WORDS - 1);

  state_t            state;
  logic [WC_W-1:0]   word_cnt;
  logic              overflow;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [NUM_CH-1:0] capture_ch;
  logic [CNT_W-1:0]  pkt_count;
  logic [CNT_W-1:0]  drop_count;

  logic              word_eop;
  logic              at_limit;
  logic              lose_word;
  logic [NUM_CH-1:0] hit_vec;

  assign word_eop  = bus.data_valid && bus.eop;
  assign at_limit  = (word_cnt == LAST_CNT);
  assign hit_vec   = bus.match & bus.enable_mask;
  assign lose_word = bus.data_valid && bus.fifo_full &&
                     ((state == S_IDLE && bus.sop) || state == S_RECEIVE);

  assign bus.wrreq = bus.data_valid && !bus.fifo_full &&
                     ((state == S_IDLE && bus.sop) || state == S_RECEIVE);
  assign bus.rdreq = (state == S_STORE || state == S_DISCARD) && !bus.rdempty;

  assign bus.clear      = (state == S_IDLE);
  assign bus.busy       = (state != S_CFG) && (state != S_IDLE);
  assign bus.state_dbg  = state;
  assign bus.mem_wr     = mem_wr;
  assign bus.mem_addr   = mem_addr;
  assign bus.capture_ch = capture_ch;
  assign bus.pkt_count  = pkt_count;
  assign bus.drop_count = drop_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_CFG;
      word_cnt   <= '0;
      overflow   <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      capture_ch <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      // FIFO data follows rdreq by one cycle, so the write strobe does too.
      mem_wr <= (state == S_STORE) && !bus.rdempty;
      if (mem_wr) begin
        mem_addr <= mem_addr + 1'b1;
      end

      case (state)
        S_CFG: begin
          if (bus.cfg_done) begin
            state <= S_IDLE;
          end
        end

        S_IDLE: begin
          if (bus.data_valid && bus.sop) begin
            word_cnt <= WC_W'(1);
            overflow <= bus.fifo_full;
            if (bus.error) begin
              state <= bus.eop ? S_DISCARD : S_ERR_WAIT;
            end else if (bus.eop) begin
              state <= bus.fifo_full ? S_DISCARD : S_DECIDE;
            end else if (at_limit) begin
              state <= S_ERR_WAIT;
            end else begin
              state <= S_RECEIVE;
            end
          end
        end

        S_RECEIVE: begin
          if (bus.data_valid) begin
            word_cnt <= word_cnt + 1'b1;
          end
          if (lose_word) begin
            overflow <= 1'b1;
          end
          if (bus.error) begin
            state <= word_eop ? S_DISCARD : S_ERR_WAIT;
          end else if (word_eop) begin
            state <= (overflow || bus.fifo_full) ? S_DISCARD : S_DECIDE;
          end else if (bus.data_valid && at_limit) begin
            state <= S_ERR_WAIT;
          end
        end

        S_DECIDE: begin
          if (|hit_vec) begin
            capture_ch <= hit_vec;
            state      <= S_STORE;
          end else begin
            state <= S_DISCARD;
          end
        end

        S_STORE: begin
          if (bus.rdempty && !mem_wr) begin
            if (pkt_count != {CNT_W{1'b1}}) begin
              pkt_count <= pkt_count + 1'b1;
            end
            word_cnt <= '0;
            overflow <= 1'b0;
            state    <= S_IDLE;
          end
        end

        S_DISCARD: begin
          if (bus.rdempty) begin
            if (drop_count != {CNT_W{1'b1}}) begin
              drop_count <= drop_count + 1'b1;
            end
            word_cnt <= '0;
            overflow <= 1'b0;
            state    <= S_IDLE;
          end
        end

        S_ERR_WAIT: begin
          if (word_eop) begin
            state <= S_DISCARD;
          end
        end

        default: state <= S_CFG;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: the bench plays the MAC, FIFO and memory,
// and a packet-level model predicts written words, addresses and counters.
module tb_capture_ctrl;
  localparam int NUM_CH    = 4;
  localparam int ADDR_W    = 3;
  localparam int MAX_WORDS = 8;
  localparam int CNT_W     = 16;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  capture_ctrl_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  capture_ctrl #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // FIFO occupancy model; the controller only sees empty/full.
  int fifo_cnt = 0;
  assign bus.rdempty = (fifo_cnt == 0);

  // Packet-level model state.
  int                m_pkt  = 0;
  int                m_drop = 0;
  logic [NUM_CH-1:0] m_cap  = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [ADDR_W-1:0] exp_q[$];

  // Per-packet observations.
  logic exp_wrreq = 1'b0;
  int   wr_seen, rd_seen, mw_seen, first_mw, last_mw;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    fifo_cnt <= fifo_cnt + int'(bus.wrreq) - int'(bus.rdreq);
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (n_rst) begin
      check("wrreq", 32'(bus.wrreq), 32'(exp_wrreq));
      if (bus.wrreq) wr_seen++;
      if (bus.rdreq) begin
        rd_seen++;
        check("rdreq_nonempty", 32'(fifo_cnt != 0), 32'd1);
      end
      if (bus.mem_wr) begin
        mw_seen++;
        if (first_mw < 0) first_mw = cyc;
        last_mw = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_mem_wr: got write at addr %0d, required none", bus.mem_addr);
        end else begin
          logic [ADDR_W-1:0] e;
          e = exp_q.pop_front();
          check("mem_wr_addr", 32'(bus.mem_addr), 32'(e));
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.data_valid = 1'b0;
    bus.sop        = 1'b0;
    bus.eop        = 1'b0;
    bus.error      = 1'b0;
    bus.fifo_full  = 1'b0;
    exp_wrreq      = 1'b0;
  endtask

  // err_at / full_at: 1-based word index carrying error / fifo_full, 0 = none.
  task automatic send_pkt(input string tag, input int n, input int err_at,
                          input int full_at, input logic [NUM_CH-1:0] m,
                          input logic [NUM_CH-1:0] en);
    int  exp_written = 0;
    int  eop_cyc = 0;
    int  t = 0;
    bit  bad, captured;
    wr_seen = 0; rd_seen = 0; mw_seen = 0; first_mw = -1; last_mw = -1;
    bus.match       = m;
    bus.enable_mask = en;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (i == 1) check({tag, "_clear_idle"}, 32'(bus.clear), 32'd1);
      if (i == 2) check({tag, "_clear_drop"}, 32'(bus.clear), 32'd0);
      bus.data_valid = 1'b1;
      bus.sop        = (i == 1);
      bus.eop        = (i == n);
      bus.error      = (i == err_at);
      bus.fifo_full  = (i == full_at);
      exp_wrreq      = (i != full_at) && (err_at == 0 || i <= err_at) && (i <= MAX_WORDS);
      if (exp_wrreq) exp_written++;
      if (i == n) eop_cyc = cyc;
    end
    @(posedge clk); #1;
    idle_inputs();

    bad      = (err_at != 0) || (full_at != 0) || (n > MAX_WORDS);
    captured = !bad && (|(m & en));
    if (captured) begin
      for (int k = 0; k < n; k++) begin
        logic [ADDR_W-1:0] a;
        a = m_addr + ADDR_W'(k);
        exp_q.push_back(a);
      end
      m_addr = m_addr + ADDR_W'(n);
      m_cap  = m & en;
      m_pkt++;
    end else begin
      m_drop++;
    end

    while (bus.busy !== 1'b0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, "_done_in_time"}, 32'(t < 60), 32'd1);
    check({tag, "_pkt_count"}, 32'(bus.pkt_count), 32'(m_pkt));
    check({tag, "_drop_count"}, 32'(bus.drop_count), 32'(m_drop));
    check({tag, "_capture_ch"}, 32'(bus.capture_ch), 32'(m_cap));
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(m_addr));
    check({tag, "_wrreq_words"}, 32'(wr_seen), 32'(exp_written));
    check({tag, "_rdreq_words"}, 32'(rd_seen), 32'(exp_written));
    check({tag, "_mem_wr_words"}, 32'(mw_seen), captured ? 32'(n) : 32'd0);
    check({tag, "_exp_q_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_fifo_empty"}, 32'(fifo_cnt), 32'd0);
    if (captured) begin
      check({tag, "_first_wr_latency"}, 32'(first_mw - eop_cyc), 32'd3);
      check({tag, "_wr_contiguous"}, 32'(last_mw - first_mw + 1), 32'(n));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst           = 1'b0;
    bus.cfg_done    = 1'b0;
    bus.match       = '0;
    bus.enable_mask = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_state_cfg", 32'(bus.state_dbg), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_clear", 32'(bus.clear), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_capture_ch", 32'(bus.capture_ch), 32'd0);
    check("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
    check("rst_drop_count", 32'(bus.drop_count), 32'd0);
    check("rst_rdreq", 32'(bus.rdreq), 32'd0);
    n_rst = 1'b1;

    @(posedge clk); #1;
    check("cfg_wait_clear", 32'(bus.clear), 32'd0);
    bus.cfg_done = 1'b1;
    @(posedge clk); #1;
    bus.cfg_done = 1'b0;
    check("cfg_done_clear", 32'(bus.clear), 32'd1);
    check("cfg_done_busy", 32'(bus.busy), 32'd0);

    send_pkt("cap4", 4, 0, 0, 4'b0010, 4'b0011);
    check("lit_cap4_pkt", 32'(bus.pkt_count), 32'd1);
    check("lit_cap4_addr", 32'(bus.mem_addr), 32'd4);
    check("lit_cap4_ch", 32'(bus.capture_ch), 32'b0010);

    send_pkt("miss4", 4, 0, 0, 4'b0010, 4'b0001);
    check("lit_miss4_drop", 32'(bus.drop_count), 32'd1);
    check("lit_miss4_ch", 32'(bus.capture_ch), 32'b0010);

    send_pkt("err2of6", 6, 2, 0, 4'b0010, 4'b0011);
    send_pkt("cap2", 2, 0, 0, 4'b0100, 4'b1111);
    check("lit_cap2_addr", 32'(bus.mem_addr), 32'd6);

    send_pkt("wrap4", 4, 0, 0, 4'b1000, 4'b1000);
    check("lit_wrap4_addr", 32'(bus.mem_addr), 32'd2);
    check("lit_wrap4_pkt", 32'(bus.pkt_count), 32'd3);

    send_pkt("giant10", 10, 0, 0, 4'b0001, 4'b0001);
    check("lit_giant10_drop", 32'(bus.drop_count), 32'd3);

    send_pkt("full3", 5, 0, 3, 4'b0001, 4'b0001);
    check("lit_full3_pkt", 32'(bus.pkt_count), 32'd3);

    send_pkt("single", 1, 0, 0, 4'b0011, 4'b0010);
    send_pkt("max8", 8, 0, 0, 4'b1111, 4'b0101);
    check("lit_max8_addr", 32'(bus.mem_addr), 32'd3);
    send_pkt("err_eop3", 3, 3, 0, 4'b0001, 4'b0001);
    check("lit_final_drop", 32'(bus.drop_count), 32'd5);
    check("lit_final_pkt", 32'(bus.pkt_count), 32'd5);

    // Reset in the middle of a packet returns everything to reset values.
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      bus.data_valid = 1'b1;
      bus.sop        = (i == 1);
      exp_wrreq      = 1'b1;
    end
    @(posedge clk); #1;
    idle_inputs();
    n_rst = 1'b0;
    #1;
    check("midrst_state", 32'(bus.state_dbg), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_pkt", 32'(bus.pkt_count), 32'd0);
    check("midrst_drop", 32'(bus.drop_count), 32'd0);
    check("midrst_addr", 32'(bus.mem_addr), 32'd0);
    check("midrst_ch", 32'(bus.capture_ch), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
